f11_wbarb: RTL

F11_WBARB -- requirements
Module: f11_wbarb

---
 rtl/f11_wbarb.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/f11_wbarb.sv
// f11_wbarb: two-master Wishbone arbiter (CPU = master 0, DMA = master 1)
// in front of a single slave port. Grants are registered and come from a
// three-state FSM. Slave-side signals are combinational muxes of the owner's
// inputs. A fair flag stops the DMA master from starving the CPU.
// Optional bus timeout: define F11_WBARB_TIMEOUT_EN to add a TMO_W-bit stall
// counter, an abort mask and the per-master err pulses. Without the macro
// the err outputs are tied low and an unacknowledged strobe waits forever.
module f11_wbarb #(
    parameter int TMO_W = 6
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // CPU master
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic        m0_ios_i,
    input  logic [21:0] m0_adr_i,
    input  logic [1:0]  m0_sel_i,
    input  logic [15:0] m0_dat_i,
    // DMA master
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [21:0] m1_adr_i,
    input  logic [1:0]  m1_sel_i,
    input  logic [15:0] m1_dat_i,
    // Master-side responses
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [15:0] m_dat_o,
    // Slave port
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic        s_ios_o,
    output logic [21:0] s_adr_o,
    output logic [1:0]  s_sel_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_fair;
    logic        r_m0_gnt;
    logic        r_m1_gnt;

    logic [1:0]  w_gnt;
    logic        w_own_cyc;
    logic        w_own_stb;
    logic        w_own_we;
    logic [21:0] w_own_adr;
    logic [1:0]  w_own_sel;
    logic [15:0] w_own_dat;
    logic        w_s_stb;
    logic        w_mask;
    logic [1:0]  w_err;
    logic [1:0]  w_ack;

    // Arbitration FSM; grants are registered alongside the state so they
    // never glitch and can never both be high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= ST_IDLE;
            r_fair   <= 1'b0;
            r_m0_gnt <= 1'b0;
            r_m1_gnt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m1_cyc_i && !r_fair) begin
                        r_state  <= ST_DMA;
                        r_m1_gnt <= 1'b1;
                    end else if (m0_cyc_i) begin
                        r_state  <= ST_CPU;
                        r_m0_gnt <= 1'b1;
                        r_fair   <= 1'b0;
                    end else if (m1_cyc_i) begin
                        r_state  <= ST_DMA;
                        r_m1_gnt <= 1'b1;
                    end
                end
                ST_CPU: begin
                    if (!m0_cyc_i) begin
                        r_state  <= ST_IDLE;
                        r_m0_gnt <= 1'b0;
                    end
                end
                ST_DMA: begin
                    if (!m1_cyc_i) begin
                        r_state  <= ST_IDLE;
                        r_m1_gnt <= 1'b0;
                        // CPU was kept waiting: it wins the next arbitration.
                        if (m0_cyc_i) begin
                            r_fair <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_m0_gnt <= 1'b0;
                    r_m1_gnt <= 1'b0;
                end
            endcase
        end
    end

    assign w_gnt = {r_m1_gnt, r_m0_gnt};

    // Owner mux: everything is zero while no master holds the bus.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_sel = '0;
        w_own_dat = '0;
        if (r_m0_gnt) begin
            w_own_cyc = m0_cyc_i;
            w_own_stb = m0_stb_i;
            w_own_we  = m0_we_i;
            w_own_adr = m0_adr_i;
            w_own_sel = m0_sel_i;
            w_own_dat = m0_dat_i;
        end else if (r_m1_gnt) begin
            w_own_cyc = m1_cyc_i;
            w_own_stb = m1_stb_i;
            w_own_we  = m1_we_i;
            w_own_adr = m1_adr_i;
            w_own_sel = m1_sel_i;
            w_own_dat = m1_dat_i;
        end
    end

    assign w_s_stb = w_own_stb & ~w_mask;

`ifdef F11_WBARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_inc;
    logic             r_mask;
    logic [1:0]       r_err;

    assign w_tmo_inc = r_tmo + TMO_ONE;

    // Stall timer: counts unacknowledged strobe cycles; on expiry it aborts
    // the owner's strobe and pulses that owner's err for one cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tmo  <= '0;
            r_mask <= 1'b0;
            r_err  <= '0;
        end else begin
            r_err <= '0;
            if (r_mask && !w_own_stb) begin
                r_mask <= 1'b0;
            end
            if ((r_state == ST_IDLE) || !w_s_stb || s_ack_i) begin
                r_tmo <= '0;
            end else if (w_tmo_inc == TMO_MAX) begin
                r_tmo  <= '0;
                r_mask <= 1'b1;
                r_err  <= w_gnt;
            end else begin
                r_tmo <= w_tmo_inc;
            end
        end
    end

    assign w_mask = r_mask;
    assign w_err  = r_err;
`else
    assign w_mask = 1'b0;
    assign w_err  = 2'b00;
`endif

    // Per-master acknowledge: only the owner, and only while strobing.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign w_ack[gi] = s_ack_i & w_gnt[gi] & w_s_stb;
        end
    endgenerate

    assign m0_gnt_o = r_m0_gnt;
    assign m1_gnt_o = r_m1_gnt;
    assign m0_ack_o = w_ack[0];
    assign m1_ack_o = w_ack[1];
    assign m0_err_o = w_err[0];
    assign m1_err_o = w_err[1];
    assign m_dat_o  = s_dat_i;

    assign s_cyc_o = w_own_cyc;
    assign s_stb_o = w_s_stb;
    assign s_we_o  = w_own_we;
    assign s_ios_o = r_m0_gnt & m0_ios_i;
    assign s_adr_o = w_own_adr;
    assign s_sel_o = w_own_sel;
    assign s_dat_o = w_own_dat;

endmodule
